mul_sched_rr: RTL

- Schedules one shared pipelined multiplier between NUM_IN in-order requesters (e.g. the three multiplier ports of the Montgomery multiplier when resources are shared).
- Requests are granted round-robin, and the number of in-flight operations is capped by a credit limit.
- Results are routed back through an order FIFO of requester indices, so ctl bits are never overwritten.
- Sits between the requesters and a single multiplier instance.

---
 rtl/mul_sched_rr_pkg.sv | 17 +
 rtl/mul_sched_rr_if.sv | 17 +
 rtl/mul_sched_rr_idx_fifo.sv | 64 ++++++
 rtl/mul_sched_rr.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mul_sched_rr_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
package mul_sched_pkg;

  // Index width for a set of n items; never collapses to zero bits.
  function automatic int idx_bits(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

  // Side-band flags that travel with every request and response.
  typedef struct packed {
    logic sop;
    logic eop;
    logic err;
    logic mod;
  } req_flags_t;

endpackage

// File: rtl/mul_sched_rr_if.sv
// Valid/ready stream carrying a data word, pass-through ctl and flags.
interface if_axi_stream #(
  parameter int DAT_BITS = 762,
  parameter int CTL_BITS = 12
);
  logic                val;
  logic                rdy;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;
  logic                sop;
  logic                eop;
  logic                err;
  logic                mod;

  modport source (output val, dat, ctl, sop, eop, err, mod, input rdy);
  modport sink   (input val, dat, ctl, sop, eop, err, mod, output rdy);
endinterface

// File: rtl/mul_sched_rr_idx_fifo.sv
// Order FIFO of requester indices; head is read from a registered pointer.
module sched_idx_fifo
  import mul_sched_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_BITS = idx_bits(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    mem_r [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_r;
  logic [PTR_BITS-1:0] rd_ptr_r;
  logic [CNT_BITS-1:0] count_r;

  // Advance a pointer with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
    return (p == PTR_BITS'(DEPTH - 1)) ? {PTR_BITS{1'b0}} : p + PTR_BITS'(1'b1);
  endfunction

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_dat;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_BITS{1'b0}};
      rd_ptr_r <= {PTR_BITS{1'b0}};
      count_r  <= {CNT_BITS{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_BITS'(1'b1);
        2'b01:   count_r <= count_r - CNT_BITS'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign empty = (count_r == {CNT_BITS{1'b0}});
  assign full  = (count_r == CNT_BITS'(DEPTH));
  assign count = count_r;

endmodule

// File: rtl/mul_sched_rr.sv
// Round-robin scheduler sharing one pipelined multiplier between NUM_IN
// in-order requesters; in-flight work is capped by MAX_OUT credits and
// results are steered back using a FIFO of issued requester indices.
module mul_sched_rr
  import mul_sched_pkg::*;
#(
  parameter int NUM_IN   = 3,
  parameter int DAT_BITS = 762,
  parameter int CTL_BITS = 12,
  parameter int MAX_OUT  = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  if_axi_stream.sink                   i_axi [NUM_IN-1:0],
  if_axi_stream.source                 o_axi [NUM_IN-1:0],
  if_axi_stream.source                 o_res,
  if_axi_stream.sink                   i_res,
  output logic [$clog2(MAX_OUT+1)-1:0] o_outstanding,
  output logic                         o_unexp_rsp
);
  localparam int IDX_BITS = idx_bits(NUM_IN);
  localparam int CNT_BITS = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    req_flags_t          flags;
  } req_t;

  req_t                req_s [NUM_IN];
  logic [NUM_IN-1:0]   req_val_s;
  logic [NUM_IN-1:0]   rsp_rdy_s;
  logic [IDX_BITS-1:0] last_grant_r;
  logic [IDX_BITS-1:0] winner_s;
  logic [IDX_BITS-1:0] cand_s;
  logic [IDX_BITS-1:0] head_s;
  logic                hit_s;
  logic                grant_vld_s;
  logic                issue_ok_s;
  logic                grant_s;
  logic                fifo_empty_s;
  logic                fifo_full_s;
  logic                res_rdy_s;
  logic                pop_s;
  logic [CNT_BITS-1:0] count_s;
  req_t                res_r;
  logic                res_val_r;
  logic                unexp_r;

  // Per-requester flattening of the interface arrays plus response steering.
  for (genvar g = 0; g < NUM_IN; g++) begin : g_port
    assign req_val_s[g] = i_axi[g].val;
    assign req_s[g]     = '{dat: i_axi[g].dat, ctl: i_axi[g].ctl,
                            flags: '{sop: i_axi[g].sop, eop: i_axi[g].eop,
                                     err: i_axi[g].err, mod: i_axi[g].mod}};
    assign i_axi[g].rdy = grant_s && (winner_s == IDX_BITS'(g));

    assign o_axi[g].val = i_res.val && !fifo_empty_s && (head_s == IDX_BITS'(g));
    assign o_axi[g].dat = i_res.dat;
    assign o_axi[g].ctl = i_res.ctl;
    assign o_axi[g].sop = i_res.sop;
    assign o_axi[g].eop = i_res.eop;
    assign o_axi[g].err = i_res.err;
    assign o_axi[g].mod = i_res.mod;
    assign rsp_rdy_s[g] = o_axi[g].rdy;
  end

  // A credit freed by this cycle's pop is not reusable until next cycle,
  // so request-side rdy never depends on response-side rdy.
  assign issue_ok_s = (!res_val_r || o_res.rdy) && !fifo_full_s;
  assign grant_s    = issue_ok_s && grant_vld_s;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    winner_s    = last_grant_r;
    grant_vld_s = 1'b0;
    cand_s      = last_grant_r;
    hit_s       = 1'b0;
    for (int k = 1; k <= NUM_IN; k++) begin
      cand_s      = IDX_BITS'((int'(last_grant_r) + k) % NUM_IN);
      hit_s       = !grant_vld_s && req_val_s[cand_s];
      winner_s    = hit_s ? cand_s : winner_s;
      grant_vld_s = grant_vld_s | hit_s;
    end
  end

  // Response ready follows the requester at the FIFO head; stray responses
  // arriving with nothing outstanding are swallowed.
  always_comb begin
    if (fifo_empty_s) begin
      res_rdy_s = 1'b1;
    end else begin
      res_rdy_s = rsp_rdy_s[head_s];
    end
  end

  assign i_res.rdy = res_rdy_s;
  assign pop_s     = i_res.val && res_rdy_s && !fifo_empty_s;

  // Round-robin pointer: moves only on an actual grant.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      last_grant_r <= IDX_BITS'(NUM_IN - 1);
    end else if (grant_s) begin
      last_grant_r <= winner_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Issue register towards the multiplier; holds its contents while stalled.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      res_val_r <= 1'b0;
      res_r     <= {$bits(req_t){1'b0}};
    end else if (grant_s) begin
      res_val_r <= 1'b1;
      res_r     <= req_s[winner_s];
    end else if (o_res.rdy) begin
      res_val_r <= 1'b0;
    end else begin
      res_val_r <= res_val_r;
    end
  end

  // Sticky flag for a response that had no matching issue.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      unexp_r <= 1'b0;
    end else if (i_res.val && fifo_empty_s) begin
      unexp_r <= 1'b1;
    end else begin
      unexp_r <= unexp_r;
    end
  end

  sched_idx_fifo #(
    .WIDTH (IDX_BITS),
    .DEPTH (MAX_OUT)
  ) u_order_fifo (
    .clk      (i_clk),
    .rst_n    (i_rst),
    .push     (grant_s),
    .push_dat (winner_s),
    .pop      (pop_s),
    .head     (head_s),
    .empty    (fifo_empty_s),
    .full     (fifo_full_s),
    .count    (count_s)
  );

  assign o_res.val     = res_val_r;
  assign o_res.dat     = res_r.dat;
  assign o_res.ctl     = res_r.ctl;
  assign o_res.sop     = res_r.flags.sop;
  assign o_res.eop     = res_r.flags.eop;
  assign o_res.err     = res_r.flags.err;
  assign o_res.mod     = res_r.flags.mod;
  assign o_outstanding = count_s;
  assign o_unexp_rsp   = unexp_r;

endmodule
